// File: rtl/xtx_accum.sv
// xtx_accum: streaming X^T X (Gram matrix) accumulator for the regression datapath.
// Accepts rows of FEAT signed features over a valid/ready handshake, accumulates the
// upper triangle of X^T X with one shared multiplier (one MAC per cycle) and serves
// any entry through a registered, mirrored read port.
//
// Optional build macro XTY_EN: adds y_data and FEAT extra X^T y accumulators that are
// swept after the pair sweep; xty[r] is read at rd_col == FEAT.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse: clear accumulators/ovf/finished, (re)arm in LOAD
//   row_valid  row_data (and y_data) valid
//   row_ready  engine accepts a row this cycle
//   row_data   feature k in bits [k*DATA_W +: DATA_W]
//   row_last   accepted row is the final sample
//   y_data     (XTY_EN only) response sample paired with row_data
//   finished   accumulation complete, held until next start
//   ovf        sticky signed accumulator overflow
//   rd_row     read row index
//   rd_col     read column index
//   result     registered read data (1-cycle latency)
module xtx_accum #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FEAT   = 2,
    parameter int unsigned ACC_W  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [FEAT*DATA_W-1:0] row_data,
    input  logic                   row_last,
`ifdef XTY_EN
    input  logic [DATA_W-1:0]      y_data,
`endif
    output logic                   finished,
    output logic                   ovf,
    input  logic [2:0]             rd_row,
    input  logic [3:0]             rd_col,
    output logic [ACC_W-1:0]       result
);

    localparam int unsigned PAIRS  = FEAT * (FEAT + 1) / 2;
    localparam int unsigned IDX_W  = $clog2(PAIRS + 1);
    localparam int unsigned FEAT_W = $clog2(FEAT + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [3:0]        FEAT4 = 4'(FEAT);
    localparam logic [FEAT_W-1:0] FLAST = FEAT_W'(FEAT - 1);
    localparam logic [IDX_W-1:0]  PLAST = IDX_W'(PAIRS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

    state_t                   state, state_nxt;
    logic [FEAT*DATA_W-1:0]   x_q;
    logic                     last_q;
    logic [FEAT_W-1:0]        i_q, j_q;
    logic [IDX_W-1:0]         p_q;
    logic                     ydo_q;     // sweeping the x*y terms after the pairs
    logic [PAIRS*ACC_W-1:0]   acc_q;     // upper triangle, row-major packed
`ifdef XTY_EN
    logic [DATA_W-1:0]        y_q;
    logic [FEAT*ACC_W-1:0]    xty_q;
`endif

    logic                     clear_c, load_c, mac_c, last_step_c;
    logic signed [DATA_W-1:0] op_a, op_b;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext, acc_cur, sum;
    logic                     ovf_c;
    logic [3:0]               rr, rc;
    logic [ACC_W-1:0]         rd_val_c;

    // Flat index of upper-triangle entry (r, c), r <= c, in row-major order.
    function automatic int unsigned tri_idx(input logic [3:0] r, input logic [3:0] c);
        int unsigned ri, ci;
        ri = 32'(r);
        ci = 32'(c);
        return ri * FEAT - (ri * (ri - 1)) / 2 + (ci - ri);
    endfunction

`ifdef XTY_EN
    assign last_step_c = ydo_q && (i_q == FLAST);
`else
    assign last_step_c = (p_q == PLAST);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath controls; start overrides everything, including a handshake
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        load_c    = 1'b0;
        mac_c     = 1'b0;
        if (start) begin
            clear_c   = 1'b1;
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                LOAD: begin
                    if (row_valid && row_ready) begin
                        load_c    = 1'b1;
                        state_nxt = MAC;
                    end
                end
                MAC: begin
                    mac_c = 1'b1;
                    if (last_step_c) state_nxt = last_q ? DONE : LOAD;
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shared multiplier and accumulate with signed overflow detection
    always_comb begin
        op_a    = $signed(x_q[i_q*DATA_W +: DATA_W]);
        op_b    = $signed(x_q[j_q*DATA_W +: DATA_W]);
        acc_cur = acc_q[p_q*ACC_W +: ACC_W];
`ifdef XTY_EN
        if (ydo_q) begin
            op_b    = $signed(y_q);
            acc_cur = xty_q[i_q*ACC_W +: ACC_W];
        end
`endif
        prod     = PROD_W'(op_a) * PROD_W'(op_b);
        prod_ext = ACC_W'(prod);
        sum      = acc_cur + prod_ext;
        ovf_c    = (acc_cur[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_cur[ACC_W-1]);
    end

    // Read decode: mirror lower triangle, out-of-range reads return zero
    always_comb begin
        rr = {1'b0, rd_row};
        rc = rd_col;
        if (rr > rc) begin
            rr = rd_col;
            rc = {1'b0, rd_row};
        end
        rd_val_c = '0;
        if (rr < FEAT4 && rc < FEAT4) rd_val_c = acc_q[tri_idx(rr, rc)*ACC_W +: ACC_W];
`ifdef XTY_EN
        if (rd_col == FEAT4 && {1'b0, rd_row} < FEAT4)
            rd_val_c = xty_q[32'(rd_row)*ACC_W +: ACC_W];
`endif
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            last_q    <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            p_q       <= '0;
            ydo_q     <= 1'b0;
            acc_q     <= '0;
`ifdef XTY_EN
            y_q       <= '0;
            xty_q     <= '0;
`endif
            row_ready <= 1'b0;
            finished  <= 1'b0;
            ovf       <= 1'b0;
            result    <= '0;
        end else begin
            row_ready <= (state_nxt == LOAD);
            finished  <= (state_nxt == DONE);
            result    <= rd_val_c;

            if (clear_c) begin
                acc_q <= '0;
`ifdef XTY_EN
                xty_q <= '0;
`endif
                ovf   <= 1'b0;
            end else if (mac_c) begin
                if (ydo_q) begin
`ifdef XTY_EN
                    xty_q[i_q*ACC_W +: ACC_W] <= sum;
`endif
                end else begin
                    acc_q[p_q*ACC_W +: ACC_W] <= sum;
                end
                if (ovf_c) ovf <= 1'b1;
            end

            if (load_c) begin
                x_q    <= row_data;
                last_q <= row_last;
`ifdef XTY_EN
                y_q    <= y_data;
`endif
                i_q    <= '0;
                j_q    <= '0;
                p_q    <= '0;
                ydo_q  <= 1'b0;
            end else if (mac_c) begin
                if (!ydo_q) begin
                    p_q <= p_q + 1'b1;
                    if (j_q == FLAST) begin
                        i_q <= i_q + 1'b1;
                        j_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
`ifdef XTY_EN
                    if (p_q == PLAST) begin
                        ydo_q <= 1'b1;
                        i_q   <= '0;
                    end
`endif
                end else begin
                    i_q <= i_q + 1'b1;
                end
            end
        end
    end

endmodule
